// File: rtl/opp_share_seq.sv
// opp_share_seq
//   Sequencer/arbiter that time-shares one external 8-bit bit-reversal unit
//   (bit i -> bit 7-i) between two requesters. Narrow operations reverse the
//   low byte of the operand. Wide operations reverse all 16 bits using two
//   byte passes through the unit, with the byte halves swapped.
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous, active-low reset
//   reqN_valid          requester N has an operation (N = 0, 1)
//   reqN_ready          requester N accepted this cycle (combinational)
//   reqN_data[15:0]     requester N operand
//   reqN_wide           1: 16-bit reverse, 0: reverse low byte only
//   opp_in[7:0]         byte driven into the shared reversal unit
//   opp_out[7:0]        reversal unit result (combinational from opp_in)
//   rsp_valid           result available
//   rsp_ready           consumer takes result
//   rsp_data[15:0]      result
//   rsp_id              requester that issued the result
//   busy                sequencer is not idle
//   ops_count[7:0]      completed responses, wraps 255 -> 0
module opp_share_seq #(
  parameter int    UUID = 0,
  parameter string NAME = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_data,
  input  logic        req0_wide,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_data,
  input  logic        req1_wide,
  output logic [7:0]  opp_in,
  input  logic [7:0]  opp_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_id,
  output logic        busy,
  output logic [7:0]  ops_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PASS_LO = 2'd1,
    PASS_HI = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        grant_id;
  logic        accept;
  logic        last_id_q;
  logic        hs;

  logic [15:0] op_data_p0;
  logic        op_wide_p0;
  logic [15:0] res_p1;
  logic        rsp_id_q;
  logic [7:0]  ops_count_q;

  // Identification-only parameters; folded into a sink so they are consumed.
  logic unused_params;
  assign unused_params = (UUID != 0) ^ (NAME == "");

  // Round robin: with both requesters valid, grant the one not served last.
  // last_id resets to 1 so the first contended grant goes to req0.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_id_q;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign accept = (state_q == IDLE) && (req0_valid || req1_valid);
  assign hs     = (state_q == RESP) && rsp_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = PASS_LO;
      PASS_LO: state_d = op_wide_p0 ? PASS_HI : RESP;
      PASS_HI: state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode. Ready is gated by rst so it reads 0 while reset is held.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    opp_in     = 8'h00;
    rsp_valid  = 1'b0;
    busy       = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        req0_ready = rst && req0_valid && !grant_id;
        req1_ready = rst && req1_valid &&  grant_id;
      end
      PASS_LO: opp_in = op_data_p0[7:0];
      PASS_HI: opp_in = op_data_p0[15:8];
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Stage p0: operand capture at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_data_p0 <= grant_id ? req1_data : req0_data;
      op_wide_p0 <= grant_id ? req1_wide : req0_wide;
    end
  end

  // Stage p1: result assembly from the shared unit, plus response bookkeeping.
  // The low-byte pass lands in the high half for wide ops (byte swap).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_p1      <= 16'h0000;
      rsp_id_q    <= 1'b0;
      last_id_q   <= 1'b1;
      ops_count_q <= 8'h00;
    end else begin
      if (accept) begin
        rsp_id_q <= grant_id;
      end
      case (state_q)
        PASS_LO: begin
          if (op_wide_p0) begin
            res_p1[15:8] <= opp_out;
          end else begin
            res_p1 <= {8'h00, opp_out};
          end
        end
        PASS_HI: res_p1[7:0] <= opp_out;
        default: ;
      endcase
      if (hs) begin
        ops_count_q <= ops_count_q + 8'd1;
        last_id_q   <= rsp_id_q;
      end
    end
  end

  assign rsp_data  = res_p1;
  assign rsp_id    = rsp_id_q;
  assign ops_count = ops_count_q;

endmodule

// File: tb/tb_opp_share_seq.sv
module tb_opp_share_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_data = 16'h0, req1_data = 16'h0;
  logic        req0_wide = 1'b0, req1_wide = 1'b0;
  logic [7:0]  opp_in, opp_out;
  logic        rsp_valid, rsp_id, busy;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_data;
  logic [7:0]  ops_count;

  opp_share_seq #(.UUID(0), .NAME("dut")) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_wide(req0_wide),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_wide(req1_wide),
    .opp_in(opp_in), .opp_out(opp_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .busy(busy), .ops_count(ops_count)
  );

  always #5 clk = ~clk;

  // External reversal unit
  always_comb begin
    for (int i = 0; i < 8; i++) opp_out[i] = opp_in[7-i];
  end

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int exp_ops = 0;
  always @(posedge clk) cyc++;

  typedef struct packed { logic id; logic [15:0] data; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every completed response against the scoreboard head
  always @(negedge clk) begin
    if (rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_rsp: got data 0x%0h id %0d expected no response", rsp_data, rsp_id);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_data", {16'h0, rsp_data}, {16'h0, mon_e.data});
        check("rsp_id", {31'h0, rsp_id}, {31'h0, mon_e.id});
      end
    end
  end

  task automatic drive_req(input logic id, input logic v, input logic [15:0] d, input logic w);
    if (id) begin req1_valid = v; req1_data = d; req1_wide = w; end
    else    begin req0_valid = v; req0_data = d; req0_wide = w; end
  endtask

  // Single operation with latency, ready-pulse, opp_in and ops_count checks
  task automatic issue_one(input logic id, input logic [15:0] d, input logic w,
                           input logic [15:0] exp_d, input logic [7:0] exp_opp, input int exp_lat);
    int n, t;
    logic rdy;
    @(posedge clk); #1;
    drive_req(id, 1'b1, d, w);
    sb.push_back('{id: id, data: exp_d});
    n = 0;
    @(negedge clk);
    rdy = id ? req1_ready : req0_ready;
    while (!rdy && n < 20) begin
      @(negedge clk); n++;
      rdy = id ? req1_ready : req0_ready;
    end
    check("req_ready", {31'h0, rdy}, 32'h1);
    t = cyc;
    @(posedge clk); #1;
    drive_req(id, 1'b0, 16'hDEAD, ~w);
    @(negedge clk);
    check("ready_pulse", {31'h0, (id ? req1_ready : req0_ready)}, 32'h0);
    check("opp_in_lo", {24'h0, opp_in}, {24'h0, exp_opp});
    n = 0;
    while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
    check("latency", cyc - t, exp_lat);
    @(posedge clk); #1;
    exp_ops = (exp_ops + 1) % 256;
    @(negedge clk);
    check("idle_after_rsp", {31'h0, busy}, 32'h0);
    check("ops_count", {24'h0, ops_count}, exp_ops);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_ops = 0;
  endtask

  initial begin
    int n, acc, hs, last_acc, want;
    logic gid;
    bit pend;
    // Reset state
    #2;
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_ops", {24'h0, ops_count}, 32'h0);
    check("rst_rsp_data", {16'h0, rsp_data}, 32'h0);
    @(posedge clk); #1; rst = 1'b1;

    // Wide and narrow single operations
    issue_one(1'b0, 16'h1234, 1'b1, 16'h2C48, 8'h34, 3);
    issue_one(1'b1, 16'hFFA1, 1'b0, 16'h0085, 8'hA1, 2);

    // Both valid continuously: grants alternate starting with req0
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{id: 1'b0, data: 16'h0080});
      sb.push_back('{id: 1'b1, data: 16'h0001});
    end
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, 16'h0001, 1'b0);
    drive_req(1'b1, 1'b1, 16'h0080, 1'b0);
    acc = 0; n = 0; last_acc = 0;
    while (acc < 4 && n < 40) begin
      @(negedge clk); n++;
      if (req0_ready || req1_ready) begin
        gid = req1_ready;
        check("alt_grant", {31'h0, gid}, acc % 2);
        if (acc > 0) check("alt_spacing", cyc - last_acc, 3);
        last_acc = cyc;
        acc++;
      end
    end
    check("alt_accepts", acc, 4);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 16'h0, 1'b0);
    drive_req(1'b1, 1'b0, 16'h0, 1'b0);
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
    exp_ops = exp_ops + 4;
    check("alt_ops", {24'h0, ops_count}, exp_ops);

    // Response stall with a competing request pending
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, 16'h00F0, 1'b0);
    sb.push_back('{id: 1'b0, data: 16'h000F});
    n = 0;
    @(negedge clk);
    while (!req0_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 16'h0, 1'b0);
    req1_valid = 1'b1; req1_data = 16'h5555; req1_wide = 1'b0;
    n = 0;
    while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'h0, rsp_valid}, 32'h1);
      check("stall_data", {16'h0, rsp_data}, 32'h000F);
      check("stall_ready1", {31'h0, req1_ready}, 32'h0);
      check("stall_busy", {31'h0, busy}, 32'h1);
      @(negedge clk);
    end
    @(posedge clk); #1; rsp_ready = 1'b1;
    @(negedge clk);
    check("hs_ready1", {31'h0, req1_ready}, 32'h0);
    @(posedge clk); #1; req1_valid = 1'b0;
    @(negedge clk);
    check("hs_idle", {31'h0, busy}, 32'h0);
    check("hs_valid_drop", {31'h0, rsp_valid}, 32'h0);
    exp_ops++;
    check("stall_ops", {24'h0, ops_count}, exp_ops);

    // Reset during PASS_HI aborts the operation
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, 16'hABCD, 1'b1);
    n = 0;
    @(negedge clk);
    while (!req0_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 16'h0, 1'b0);
    @(posedge clk); #1;
    check("pass_hi_opp", {24'h0, opp_in}, 32'hAB);
    req1_valid = 1'b1;
    rst = 1'b0;
    #1;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_opp", {24'h0, opp_in}, 32'h0);
    check("abort_ops", {24'h0, ops_count}, 32'h0);
    check("abort_ready1", {31'h0, req1_ready}, 32'h0);
    check("abort_data", {16'h0, rsp_data}, 32'h0);
    check("abort_valid", {31'h0, rsp_valid}, 32'h0);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    rst = 1'b1;
    exp_ops = 0;
    issue_one(1'b1, 16'h0003, 1'b0, 16'h00C0, 8'h03, 2);

    // Counter wrap: 257 narrow operations back to back
    do_reset();
    for (int i = 0; i < 257; i++) sb.push_back('{id: 1'b0, data: 16'h0080});
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, 16'h0001, 1'b0);
    acc = 0; hs = 0; n = 0; pend = 1'b0;
    while (hs < 257 && n < 1200) begin
      @(negedge clk); n++;
      if (pend) begin
        check("wrap_zero", {24'h0, ops_count}, 32'h00);
        pend = 1'b0;
      end
      if (req0_ready) acc++;
      if (rsp_valid && rsp_ready) begin
        hs++;
        if (hs == 256) begin
          check("pre_wrap", {24'h0, ops_count}, 32'hFF);
          pend = 1'b1;
        end
      end
      @(posedge clk); #1;
      if (acc >= 257) req0_valid = 1'b0;
    end
    check("wrap_handshakes", hs, 257);
    @(negedge clk);
    check("wrap_one", {24'h0, ops_count}, 32'h01);
    want = 0;
    check("sb_empty", sb.size(), want);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/opp_share_seq.md
Name: opp_share_seq

Overview:
- Sequencer and arbiter that shares one 8-bit bit-reversal unit (OPP-style: bit i maps to bit 7-i) between two requesters.
- Supports 8-bit reversal, or full 16-bit reversal built from two byte passes through the shared unit with the byte halves swapped.
- Sits between the register/ALU side of the CPU (requesters) and the single reversal datapath instance.
- Produces registered results through a valid/ready response port.

Parameters:
UUID, 0, instance identifier (codebase convention, no functional effect)
NAME, "", instance name (codebase convention, no functional effect)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; asynchronous, active-low
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 accepted this cycle
req0_data  in  16  requester 0 operand
req0_wide  in  1  1: 16-bit reverse; 0: reverse low byte only
req1_valid / req1_ready / req1_data / req1_wide  same as requester 0, for requester 1
opp_in  out  8  byte driven into shared reversal unit
opp_out  in  8  reversal unit result; combinational from opp_in
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_data  out  16  result
rsp_id  out  1  requester that issued the result
busy  out  1  high whenever state != IDLE
ops_count  out  8  completed responses, wraps 255->0

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - rsp_valid, rsp_data, rsp_id, busy, ops_count, opp_in and both ready outputs are 0.
  - Round-robin pointer set so req0 has priority.
  - Any in-flight operation is discarded and no response is produced.
- States: IDLE, PASS_LO, PASS_HI, RESP.
- IDLE:
  - If either valid is high, grant one requester.
  - If both are valid, grant the one not served last; the first grant after reset goes to req0.
  - reqN_ready = reqN_valid & granted & (state==IDLE); it is combinational and high for exactly that cycle.
  - On acceptance, latch data, wide and id, then go to PASS_LO.
  - No valid: stay in IDLE.
- PASS_LO:
  - opp_in = latched data[7:0].
  - If wide: capture opp_out into result[15:8], go to PASS_HI.
  - If not wide: capture opp_out into result[7:0], set result[15:8]=0, go to RESP.
- PASS_HI:
  - opp_in = latched data[15:8].
  - Capture opp_out into result[7:0], go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id stay stable until handshake.
  - On rsp_valid & rsp_ready: ops_count += 1 (mod 256), update round-robin pointer to the served id, go to IDLE. rsp_valid drops the following cycle.
  - No new request is accepted while in RESP, even in the handshake cycle.
- opp_in = 0 in IDLE and RESP.
- Latency, measured from the acceptance edge at cycle T:
  - rsp_valid high at T+2 for narrow operations, T+3 for wide.
  - Minimum spacing between accepts is 3 cycles (narrow) and 4 cycles (wide).
- Inputs are sampled only at acceptance. A requester dropping valid or changing data afterwards has no effect on the operation in flight.
- A requester whose valid drops before it is granted loses nothing; its request is not remembered.

Test Plan:
- Reset, then req0 valid, wide=1, data=0x1234 -> req0_ready pulse 1 cycle; rsp_valid at T+3 with rsp_data=0x2C48, rsp_id=0; ops_count 0->1 after handshake.
- req1 valid, wide=0, data=0xFFA1 -> rsp_data=0x0085, rsp_id=1, rsp_valid at T+2; opp_in observed as 0xA1 in PASS_LO.
- Both valid continuously, wide=0, data0=0x0001, data1=0x0080 -> grants alternate 0,1,0,1; responses 0x0080, 0x0001 repeating; accepts 3 cycles apart.
- rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rsp_data stable, req ready stays 0, busy=1; release -> handshake, IDLE next cycle.
- rst asserted in PASS_HI mid-edge -> all outputs 0 immediately; after release, req1 alone valid is granted and the aborted operation never responds.
- 256 narrow operations back to back -> ops_count wraps to 0x00; 257th response brings it to 0x01.
